// File: rtl/apb_slave_mux.sv
// APB slave-side decoder/mux: one-hot select from a PADDR field, response muxing, unmapped-access errors.
// Optional wait-state watchdog with ABORT state is enabled by defining APB_SLAVE_MUX_TIMEOUT_EN.
module apb_slave_mux #(
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 16,
    parameter int SEL_BITS       = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [31:0]                    PADDR,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    output logic [NUM_SLAVES-1:0]          PSEL_slave,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA_in,
    input  logic [NUM_SLAVES-1:0]          PREADY_in,
    input  logic [NUM_SLAVES-1:0]          PSLVERR_in,
    output logic [DATA_WIDTH-1:0]          PRDATA_out,
    output logic                           PREADY_out,
    output logic                           PSLVERR_out,
    output logic                           err_flag,
    output logic [31:0]                    err_addr,
    input  logic                           err_clr,
    output logic [1:0]                     fsm_state
);

    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        UNMAPPED = 2'd2
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
        , ABORT  = 2'd3
`endif
    } state_t;

    state_t          state;
    logic [IW-1:0]   sel_q;
    logic [31:0]     addr_q;
    logic [SEL_BITS-1:0] idx;
    logic [IW-1:0]   idx_s;
    logic            mapped;
    logic            setup;
    logic            err_set;

`ifdef APB_SLAVE_MUX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt;
`endif

    assign idx    = PADDR[SEL_LSB +: SEL_BITS];
    assign idx_s  = idx[IW-1:0];
    assign mapped = (32'(idx) < 32'(NUM_SLAVES));
    assign setup  = PSEL && !PENABLE;
    assign fsm_state = state;

`ifdef APB_SLAVE_MUX_TIMEOUT_EN
    assign err_set = PSEL && ((state == UNMAPPED) || (state == ABORT));
`else
    assign err_set = PSEL && (state == UNMAPPED);
`endif

    // Select and response are combinational so the bridge sees zero added latency.
    always_comb begin
        PSEL_slave  = '0;
        PRDATA_out  = '0;
        PREADY_out  = 1'b0;
        PSLVERR_out = 1'b0;
        case (state)
            IDLE: begin
                if (!RST && setup && mapped)
                    PSEL_slave = NUM_SLAVES'(1) << idx_s;
            end
            ACCESS: begin
                PSEL_slave  = NUM_SLAVES'(1) << sel_q;
                PRDATA_out  = PRDATA_in[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
                PREADY_out  = PREADY_in[sel_q];
                PSLVERR_out = PSLVERR_in[sel_q];
            end
            UNMAPPED: begin
                PREADY_out  = 1'b1;
                PSLVERR_out = 1'b1;
            end
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
            ABORT: begin
                PREADY_out  = 1'b1;
                PSLVERR_out = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            sel_q    <= '0;
            addr_q   <= '0;
            err_flag <= 1'b0;
            err_addr <= '0;
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
            cnt      <= '0;
`endif
        end else begin
            // A new error takes priority over a same-cycle clear.
            if (err_set) begin
                err_flag <= 1'b1;
                err_addr <= addr_q;
            end else if (err_clr) begin
                err_flag <= 1'b0;
                err_addr <= '0;
            end

            case (state)
                IDLE: begin
                    if (setup) begin
                        addr_q <= PADDR;
                        if (mapped) begin
                            sel_q <= idx_s;
                            state <= ACCESS;
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
                            cnt   <= '0;
`endif
                        end else begin
                            state <= UNMAPPED;
                        end
                    end
                end
                ACCESS: begin
                    if (!PSEL || PREADY_in[sel_q]) begin
                        state <= IDLE;
                    end
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
                    else begin
                        if (cnt == T_LAST)
                            state <= ABORT;
                        if (cnt != T_MAX)
                            cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_mux.sv
// Directed bench for apb_slave_mux: reset, waited read, unmapped, watchdog/hang, back-to-back,
// PSEL drop, mid-transfer reset and sticky error clear priority.
module tb_apb_slave_mux;

    localparam int NS = 4;
    localparam int DW = 32;

    logic           CLK = 1'b0;
    logic           RST;
    logic [31:0]    PADDR;
    logic           PSEL, PENABLE;
    logic [NS-1:0]  PSEL_slave;
    logic [NS*DW-1:0] PRDATA_in;
    logic [NS-1:0]  PREADY_in, PSLVERR_in;
    logic [DW-1:0]  PRDATA_out;
    logic           PREADY_out, PSLVERR_out;
    logic           err_flag;
    logic [31:0]    err_addr;
    logic           err_clr;
    logic [1:0]     fsm_state;

    int checks = 0;
    int passed = 0;

    apb_slave_mux #(
        .NUM_SLAVES(NS), .SEL_LSB(16), .SEL_BITS(8), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK(CLK), .RST(RST), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PSEL_slave(PSEL_slave), .PRDATA_in(PRDATA_in), .PREADY_in(PREADY_in),
        .PSLVERR_in(PSLVERR_in), .PRDATA_out(PRDATA_out), .PREADY_out(PREADY_out),
        .PSLVERR_out(PSLVERR_out), .err_flag(err_flag), .err_addr(err_addr),
        .err_clr(err_clr), .fsm_state(fsm_state)
    );

    always #5 CLK = ~CLK;

    // Observed bus view: {state, select, ready, slverr, rdata} = 40 bits.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; PADDR = 32'h0002_0010; PSEL = 1'b1; PENABLE = 1'b0; err_clr = 1'b0;
        tick(); tick(); #1;
        checks++;
        if ({fsm_state, PSEL_slave, PREADY_out, PSLVERR_out, PRDATA_out} !== 40'h0_0_0_00000000)
            $display("FAIL reset_bus: got %h want %h",
                     {fsm_state, PSEL_slave, PREADY_out, PSLVERR_out, PRDATA_out}, 40'h0);
        else passed++;
        checks++;
        if ({err_flag, err_addr} !== 33'h0)
            $display("FAIL reset_err: got %h want 0", {err_flag, err_addr});
        else passed++;
        PSEL = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_read_wait();
        PREADY_in = 4'b1011; PSLVERR_in = 4'b1011;
        tick();
        PADDR = 32'h0002_0010; PSEL = 1'b1; PENABLE = 1'b0; #1;
        checks++;
        if ({fsm_state, PSEL_slave, PREADY_out} !== {2'd0, 4'b0100, 1'b0})
            $display("FAIL rd_setup: got %b want %b", {fsm_state, PSEL_slave, PREADY_out}, {2'd0, 4'b0100, 1'b0});
        else passed++;
        for (int k = 0; k < 2; k++) begin
            tick();
            PENABLE = 1'b1;
            if (k == 1) PADDR = 32'h0001_0000;
            #1;
            checks++;
            if ({fsm_state, PSEL_slave, PREADY_out} !== {2'd1, 4'b0100, 1'b0})
                $display("FAIL rd_wait%0d: got %b want %b", k, {fsm_state, PSEL_slave, PREADY_out}, {2'd1, 4'b0100, 1'b0});
            else passed++;
        end
        tick();
        PREADY_in[2] = 1'b1; #1;
        checks++;
        if ({fsm_state, PSEL_slave, PREADY_out, PSLVERR_out, PRDATA_out} !== {2'd1, 4'b0100, 1'b1, 1'b0, 32'hDEADBEEF})
            $display("FAIL rd_done: got %h want %h", {fsm_state, PSEL_slave, PREADY_out, PSLVERR_out, PRDATA_out},
                     {2'd1, 4'b0100, 1'b1, 1'b0, 32'hDEADBEEF});
        else passed++;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PREADY_in[2] = 1'b0; #1;
        checks++;
        if ({fsm_state, PSEL_slave, PREADY_out, err_flag} !== {2'd0, 4'b0000, 1'b0, 1'b0})
            $display("FAIL rd_idle: got %b want %b", {fsm_state, PSEL_slave, PREADY_out, err_flag}, 8'b0);
        else passed++;
    endtask

    task automatic test_unmapped();
        tick();
        PADDR = 32'h0009_0000; PSEL = 1'b1; PENABLE = 1'b0; #1;
        checks++;
        if ({PSEL_slave, PREADY_out} !== 5'b0)
            $display("FAIL um_setup: got %b want 00000", {PSEL_slave, PREADY_out});
        else passed++;
        tick();
        PENABLE = 1'b1; #1;
        checks++;
        if ({fsm_state, PSEL_slave, PREADY_out, PSLVERR_out, PRDATA_out} !== {2'd2, 4'b0000, 1'b1, 1'b1, 32'h0})
            $display("FAIL um_err: got %h want %h", {fsm_state, PSEL_slave, PREADY_out, PSLVERR_out, PRDATA_out},
                     {2'd2, 4'b0000, 1'b1, 1'b1, 32'h0});
        else passed++;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; #1;
        checks++;
        if ({err_flag, err_addr, PREADY_out, fsm_state} !== {1'b1, 32'h0009_0000, 1'b0, 2'd0})
            $display("FAIL um_log: got %h want %h", {err_flag, err_addr, PREADY_out, fsm_state},
                     {1'b1, 32'h0009_0000, 1'b0, 2'd0});
        else passed++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0; #1;
        checks++;
        if ({err_flag, err_addr} !== 33'h0)
            $display("FAIL um_clr: got %h want 0", {err_flag, err_addr});
        else passed++;
    endtask

    task automatic test_watchdog();
        PREADY_in = 4'b1101; PSLVERR_in = 4'b0000;
        tick();
        PADDR = 32'h0001_0000; PSEL = 1'b1; PENABLE = 1'b0; #1;
        checks++;
        if (PSEL_slave !== 4'b0010)
            $display("FAIL wd_setup: got %b want 0010", PSEL_slave);
        else passed++;
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            tick();
            PENABLE = 1'b1; #1;
            checks++;
            if ({fsm_state, PSEL_slave, PREADY_out} !== {2'd1, 4'b0010, 1'b0})
                $display("FAIL wd_wait%0d: got %b want %b", k, {fsm_state, PSEL_slave, PREADY_out}, {2'd1, 4'b0010, 1'b0});
            else passed++;
        end
        tick(); #1;
        checks++;
        if ({fsm_state, PSEL_slave, PREADY_out, PSLVERR_out, PRDATA_out} !== {2'd3, 4'b0000, 1'b1, 1'b1, 32'h0})
            $display("FAIL wd_abort: got %h want %h", {fsm_state, PSEL_slave, PREADY_out, PSLVERR_out, PRDATA_out},
                     {2'd3, 4'b0000, 1'b1, 1'b1, 32'h0});
        else passed++;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; #1;
        checks++;
        if ({err_flag, err_addr, fsm_state} !== {1'b1, 32'h0001_0000, 2'd0})
            $display("FAIL wd_log: got %h want %h", {err_flag, err_addr, fsm_state}, {1'b1, 32'h0001_0000, 2'd0});
        else passed++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
`else
        for (int k = 0; k < 100; k++) begin
            tick();
            PENABLE = 1'b1; #1;
            checks++;
            if ({fsm_state, PSEL_slave, PREADY_out} !== {2'd1, 4'b0010, 1'b0})
                $display("FAIL wd_hang%0d: got %b want %b", k, {fsm_state, PSEL_slave, PREADY_out}, {2'd1, 4'b0010, 1'b0});
            else passed++;
        end
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; #1;
        tick(); #1;
        checks++;
        if ({fsm_state, PSEL_slave, err_flag} !== {2'd0, 4'b0000, 1'b0})
            $display("FAIL wd_drop: got %b want 0000000", {fsm_state, PSEL_slave, err_flag});
        else passed++;
`endif
    endtask

    task automatic test_back_to_back();
        PREADY_in = 4'b1111; PSLVERR_in = 4'b1000;
        tick();
        PADDR = 32'h0000_0004; PSEL = 1'b1; PENABLE = 1'b0; #1;
        checks++;
        if ({PSEL_slave, PREADY_out} !== {4'b0001, 1'b0})
            $display("FAIL b2b_c1: got %b want 00010", {PSEL_slave, PREADY_out});
        else passed++;
        tick();
        PENABLE = 1'b1; #1;
        checks++;
        if ({PSEL_slave, PREADY_out, PSLVERR_out, PRDATA_out} !== {4'b0001, 1'b1, 1'b0, 32'h1111_1111})
            $display("FAIL b2b_c2: got %h want %h", {PSEL_slave, PREADY_out, PSLVERR_out, PRDATA_out},
                     {4'b0001, 1'b1, 1'b0, 32'h1111_1111});
        else passed++;
        tick();
        PADDR = 32'h0003_0008; PENABLE = 1'b0; #1;
        checks++;
        if ({fsm_state, PSEL_slave, PREADY_out} !== {2'd0, 4'b1000, 1'b0})
            $display("FAIL b2b_c3: got %b want %b", {fsm_state, PSEL_slave, PREADY_out}, {2'd0, 4'b1000, 1'b0});
        else passed++;
        tick();
        PENABLE = 1'b1; #1;
        checks++;
        if ({PSEL_slave, PREADY_out, PSLVERR_out, PRDATA_out} !== {4'b1000, 1'b1, 1'b1, 32'h4444_4444})
            $display("FAIL b2b_c4: got %h want %h", {PSEL_slave, PREADY_out, PSLVERR_out, PRDATA_out},
                     {4'b1000, 1'b1, 1'b1, 32'h4444_4444});
        else passed++;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; #1;
        checks++;
        if ({fsm_state, PREADY_out, err_flag} !== 4'b0)
            $display("FAIL b2b_end: got %b want 0000", {fsm_state, PREADY_out, err_flag});
        else passed++;
    endtask

    task automatic test_psel_drop();
        PREADY_in = 4'b0000;
        tick();
        PADDR = 32'h0003_0000; PSEL = 1'b1; PENABLE = 1'b0;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
        tick(); #1;
        checks++;
        if ({fsm_state, PSEL_slave, PREADY_out, err_flag} !== 8'b0)
            $display("FAIL drop_idle: got %b want 00000000", {fsm_state, PSEL_slave, PREADY_out, err_flag});
        else passed++;
    endtask

    task automatic test_reset_mid();
        PREADY_in = 4'b0000;
        tick();
        PADDR = 32'h0001_0020; PSEL = 1'b1; PENABLE = 1'b0;
        tick();
        PENABLE = 1'b1; #1;
        checks++;
        if (PSEL_slave !== 4'b0010)
            $display("FAIL rst_pre: got %b want 0010", PSEL_slave);
        else passed++;
        #1 RST = 1'b1; #1;
        checks++;
        if ({fsm_state, PSEL_slave, PREADY_out, PSLVERR_out, err_flag} !== 9'b0)
            $display("FAIL rst_mid: got %b want 000000000", {fsm_state, PSEL_slave, PREADY_out, PSLVERR_out, err_flag});
        else passed++;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; RST = 1'b0;
        tick(); #1;
        checks++;
        if ({fsm_state, err_flag, err_addr} !== 35'h0)
            $display("FAIL rst_after: got %h want 0", {fsm_state, err_flag, err_addr});
        else passed++;
    endtask

    task automatic test_err_clr();
        tick();
        PADDR = 32'h00FF_1234; PSEL = 1'b1; PENABLE = 1'b0;
        tick();
        PENABLE = 1'b1; err_clr = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; #1;
        checks++;
        if ({err_flag, err_addr} !== {1'b1, 32'h00FF_1234})
            $display("FAIL clr_collide: got %h want %h", {err_flag, err_addr}, {1'b1, 32'h00FF_1234});
        else passed++;
        tick();
        err_clr = 1'b0; #1;
        checks++;
        if ({err_flag, err_addr} !== 33'h0)
            $display("FAIL clr_after: got %h want 0", {err_flag, err_addr});
        else passed++;
    endtask

    initial begin
        PRDATA_in  = {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
        PREADY_in  = '0;
        PSLVERR_in = '0;
        test_reset();
        test_read_wait();
        test_unmapped();
        test_watchdog();
        test_back_to_back();
        test_psel_drop();
        test_reset_mid();
        test_err_clr();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
